// File: rtl/rr_grant_arbiter8_if.sv
// Request/grant bundle between eight requesting units and the round-robin
// arbiter that owns the shared 8-way resource.
//
//   req        8  requester i holds req[i]=1 while it wants or owns the resource
//   gnt        8  registered one-hot grant, zero when nobody owns the resource
//   gnt_idx    3  binary index of the current (or most recent) owner
//   gnt_valid  1  high while a grant is held
//   preempt    1  one-cycle pulse after an owner is forced off by the hold timeout
//
// master: the requester side (drives req, observes the grant)
// slave : the arbiter side (observes req, drives the grant)
interface rr_grant_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );
endinterface

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter sharing one 8-way resource among eight requesters.
// The grant is registered and held until its owner drops req or, when
// MAX_HOLD is non-zero, until the owner has held it for MAX_HOLD cycles.
// Every ownership change passes through one IDLE cycle with gnt=0.
//
// Parameters:
//   MAX_HOLD  max consecutive cycles one owner may hold the grant (0 = no limit)
//   HOLD_W    hold counter width, 2**HOLD_W must exceed MAX_HOLD
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   arb  request/grant bundle (slave side): req in; gnt, gnt_idx,
//        gnt_valid, preempt out, all registered
module rr_grant_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_grant_arbiter8_if.slave   arb
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    logic [0:0]        state;
    logic [2:0]        last_idx;
    logic [HOLD_W-1:0] hold_cnt;

    logic [7:0]        gnt_r;
    logic [2:0]        idx_r;
    logic              vld_r;
    logic              pre_r;

    logic [2:0]        sel;
    logic              sel_found;
    logic [2:0]        cand;

    logic              owner_req;
    logic              release_now;

    // Scan last_idx+1, last_idx+2, ... modulo 8; the 3-bit add wraps for free,
    // and offset 8 lands back on last_idx so it is considered last.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= 8; k++) begin
            cand = last_idx + 3'(k);
            if (!sel_found && arb.req[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    assign owner_req   = arb.req[idx_r];
    assign release_now = !owner_req || (TIMEOUT_EN && (hold_cnt == HOLD_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_r    <= '0;
            idx_r    <= '0;
            vld_r    <= 1'b0;
            pre_r    <= 1'b0;
            hold_cnt <= '0;
            last_idx <= 3'd7;
        end else begin
            pre_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        gnt_r    <= 8'b1 << sel;
                        idx_r    <= sel;
                        vld_r    <= 1'b1;
                        hold_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (release_now) begin
                        // Releasing owner becomes lowest priority next round.
                        // preempt only when the owner still wanted the grant.
                        gnt_r    <= '0;
                        vld_r    <= 1'b0;
                        last_idx <= idx_r;
                        pre_r    <= owner_req;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb.gnt       = gnt_r;
    assign arb.gnt_idx   = idx_r;
    assign arb.gnt_valid = vld_r;
    assign arb.preempt   = pre_r;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Directed bench for rr_grant_arbiter8. Three instances share clk/rst:
//   dut_a  MAX_HOLD=16 (priority, fairness, wrap-around, mid-grant reset)
//   dut_b  MAX_HOLD=4  (timeout and timeout fairness)
//   dut_c  MAX_HOLD=0  (no timeout)
// Observed vectors are {gnt, gnt_idx, gnt_valid, preempt}.
module tb_rr_grant_arbiter8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    rr_grant_arbiter8_if ifa ();
    rr_grant_arbiter8_if ifb ();
    rr_grant_arbiter8_if ifc ();

    rr_grant_arbiter8 #(.MAX_HOLD(16), .HOLD_W(5)) dut_a (.clk(clk), .rst(rst), .arb(ifa));
    rr_grant_arbiter8 #(.MAX_HOLD(4),  .HOLD_W(3)) dut_b (.clk(clk), .rst(rst), .arb(ifb));
    rr_grant_arbiter8 #(.MAX_HOLD(0),  .HOLD_W(5)) dut_c (.clk(clk), .rst(rst), .arb(ifc));

    logic [12:0] obs_a, obs_b, obs_c;
    assign obs_a = {ifa.gnt, ifa.gnt_idx, ifa.gnt_valid, ifa.preempt};
    assign obs_b = {ifb.gnt, ifb.gnt_idx, ifb.gnt_valid, ifb.preempt};
    assign obs_c = {ifc.gnt, ifc.gnt_idx, ifc.gnt_valid, ifc.preempt};

    int n_checks = 0;
    int n_fail   = 0;

    // Advance one rising edge; outputs are then sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] exp_v;
        ifa.req = 8'h00;
        ifb.req = 8'h00;
        ifc.req = 8'h00;
        rst = 1'b1;
        step();
        step();
        exp_v = '0;
        n_checks++;
        if (obs_a !== exp_v) begin n_fail++; $display("FAIL reset_a: got %h expected %h", obs_a, exp_v); end
        n_checks++;
        if (obs_b !== exp_v) begin n_fail++; $display("FAIL reset_b: got %h expected %h", obs_b, exp_v); end
        n_checks++;
        if (obs_c !== exp_v) begin n_fail++; $display("FAIL reset_c: got %h expected %h", obs_c, exp_v); end
        rst = 1'b0;
        step();
        n_checks++;
        if (obs_a !== exp_v) begin n_fail++; $display("FAIL idle_no_req: got %h expected %h", obs_a, exp_v); end
    endtask

    task automatic test_priority();
        logic [12:0] exp_v;
        do_reset();
        ifa.req = 8'h01;
        step();
        exp_v = {8'h01, 3'd0, 1'b1, 1'b0};
        n_checks++;
        if (obs_a !== exp_v) begin n_fail++; $display("FAIL prio_grant0: got %h expected %h", obs_a, exp_v); end
        ifa.req = 8'h00;
        step();
        exp_v = {8'h00, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (obs_a !== exp_v) begin n_fail++; $display("FAIL prio_release: got %h expected %h", obs_a, exp_v); end
    endtask

    task automatic test_fairness();
        logic [12:0] exp_v;
        logic [2:0]  k3;
        do_reset();
        ifa.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            k3 = 3'(k % 8);
            exp_v = {8'b1 << k3, k3, 1'b1, 1'b0};
            n_checks++;
            if (obs_a !== exp_v) begin n_fail++; $display("FAIL fair_grant%0d: got %h expected %h", k, obs_a, exp_v); end
            ifa.req[k3] = 1'b0;
            step();
            exp_v = {8'h00, k3, 1'b0, 1'b0};
            n_checks++;
            if (obs_a !== exp_v) begin n_fail++; $display("FAIL fair_gap%0d: got %h expected %h", k, obs_a, exp_v); end
            ifa.req = 8'hFF;
        end
        ifa.req = 8'h00;
        step();
        step();
    endtask

    task automatic test_wrap();
        logic [12:0] exp_v;
        do_reset();
        ifa.req = 8'h40;
        step();
        exp_v = {8'h40, 3'd6, 1'b1, 1'b0};
        n_checks++;
        if (obs_a !== exp_v) begin n_fail++; $display("FAIL wrap_own6: got %h expected %h", obs_a, exp_v); end
        ifa.req = 8'b0010_0001;
        step();
        exp_v = {8'h00, 3'd6, 1'b0, 1'b0};
        n_checks++;
        if (obs_a !== exp_v) begin n_fail++; $display("FAIL wrap_release: got %h expected %h", obs_a, exp_v); end
        step();
        exp_v = {8'h01, 3'd0, 1'b1, 1'b0};
        n_checks++;
        if (obs_a !== exp_v) begin n_fail++; $display("FAIL wrap_next0: got %h expected %h", obs_a, exp_v); end
        ifa.req = 8'h00;
        step();
    endtask

    task automatic test_timeout();
        logic [12:0] exp_v;
        do_reset();
        ifb.req = 8'h08;
        step();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            exp_v = {8'h08, 3'd3, 1'b1, 1'b0};
            n_checks++;
            if (obs_b !== exp_v) begin n_fail++; $display("FAIL tmo_hold%0d: got %h expected %h", c, obs_b, exp_v); end
        end
        step();
        exp_v = {8'h00, 3'd3, 1'b0, 1'b1};
        n_checks++;
        if (obs_b !== exp_v) begin n_fail++; $display("FAIL tmo_preempt: got %h expected %h", obs_b, exp_v); end
        step();
        exp_v = {8'h08, 3'd3, 1'b1, 1'b0};
        n_checks++;
        if (obs_b !== exp_v) begin n_fail++; $display("FAIL tmo_regrant: got %h expected %h", obs_b, exp_v); end
        ifb.req = 8'h00;
        step();
        exp_v = {8'h00, 3'd3, 1'b0, 1'b0};
        n_checks++;
        if (obs_b !== exp_v) begin n_fail++; $display("FAIL tmo_vol_release: got %h expected %h", obs_b, exp_v); end
    endtask

    task automatic test_timeout_fair();
        logic [12:0] exp_v;
        logic [2:0]  own;
        do_reset();
        ifb.req = 8'h0C;
        step();
        for (int r = 0; r < 4; r++) begin
            own = (r % 2 == 0) ? 3'd2 : 3'd3;
            for (int c = 0; c < 4; c++) begin
                exp_v = {8'b1 << own, own, 1'b1, 1'b0};
                n_checks++;
                if (obs_b !== exp_v) begin n_fail++; $display("FAIL tfair_r%0d_c%0d: got %h expected %h", r, c, obs_b, exp_v); end
                step();
            end
            exp_v = {8'h00, own, 1'b0, 1'b1};
            n_checks++;
            if (obs_b !== exp_v) begin n_fail++; $display("FAIL tfair_gap%0d: got %h expected %h", r, obs_b, exp_v); end
            step();
        end
        ifb.req = 8'h00;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        logic [12:0] exp_v;
        do_reset();
        ifa.req = 8'h20;
        step();
        exp_v = {8'h20, 3'd5, 1'b1, 1'b0};
        n_checks++;
        if (obs_a !== exp_v) begin n_fail++; $display("FAIL rmid_own5: got %h expected %h", obs_a, exp_v); end
        rst = 1'b1;
        step();
        exp_v = '0;
        n_checks++;
        if (obs_a !== exp_v) begin n_fail++; $display("FAIL rmid_cleared: got %h expected %h", obs_a, exp_v); end
        rst = 1'b0;
        ifa.req = 8'h21;
        step();
        exp_v = {8'h01, 3'd0, 1'b1, 1'b0};
        n_checks++;
        if (obs_a !== exp_v) begin n_fail++; $display("FAIL rmid_grant0: got %h expected %h", obs_a, exp_v); end
        ifa.req = 8'h00;
        step();
    endtask

    task automatic test_no_timeout();
        logic [12:0] exp_v;
        do_reset();
        ifc.req = 8'h80;
        exp_v = {8'h80, 3'd7, 1'b1, 1'b0};
        for (int c = 0; c < 100; c++) begin
            step();
            n_checks++;
            if (obs_c !== exp_v) begin n_fail++; $display("FAIL notmo_cyc%0d: got %h expected %h", c, obs_c, exp_v); end
        end
        ifc.req = 8'h00;
        step();
        exp_v = {8'h00, 3'd7, 1'b0, 1'b0};
        n_checks++;
        if (obs_c !== exp_v) begin n_fail++; $display("FAIL notmo_release: got %h expected %h", obs_c, exp_v); end
    endtask

    initial begin
        ifa.req = 8'h00;
        ifb.req = 8'h00;
        ifc.req = 8'h00;
        test_reset();
        test_priority();
        test_fairness();
        test_wrap();
        test_timeout();
        test_timeout_fair();
        test_reset_mid();
        test_no_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
